mips_avalon_ram: RTL and testbench

Parametrised Avalon memory-mapped slave RAM. It is the successor to the fixed 32-bit instruction/data test slave. It generalises data width, base address, depth and read/write wait states, and adds several features:
- a deterministic pseudo-random stall mode;
- a read-only region option;
- a latched request address;
- abort on request withdrawal;
- a registered bus-error flag.

It sits on the CPU instruction or data Avalon port in the testbench and can be instanced once per region.

---
 rtl/mips_avalon_pkg.sv | 23 ++
 rtl/mips_avalon_ram_lfsr.sv | 20 ++
 rtl/mips_avalon_ram.sv | 176 +++++++++++++++++
 tb/tb_mips_avalon_ram.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_avalon_pkg.sv
// Shared types and helpers for the parametrised Avalon slave RAM.
package mips_avalon_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } avalon_state_t;

    // Right-shifting Galois mask for x^8 + x^6 + x^5 + x^4 + 1
    localparam logic [7:0] LFSR_POLY = 8'hB8;

    // Ceiling log2; clog2(1) = 0
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned bits;
        bits = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) bits = i + 1;
        end
        return bits;
    endfunction

endpackage

// File: rtl/mips_avalon_ram_lfsr.sv
// 8-bit Galois LFSR supplying the pseudo-random stall pattern.
module mips_lfsr8
    import mips_avalon_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] seed,
    output logic [7:0] out
);

    // Advance one step every cycle outside reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out <= seed;
        end else begin
            out <= {1'b0, out[7:1]} ^ (out[0] ? LFSR_POLY : 8'h00);
        end
    end

endmodule

// File: rtl/mips_avalon_ram.sv
// Parametrised Avalon-MM slave RAM with fixed or pseudo-random wait states,
// optional read-only region, abort on request withdrawal and a bus-error flag.
module mips_avalon_ram
  import mips_avalon_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter logic [31:0] BASE_ADDR   = 32'hBFC00000,
  parameter int unsigned MEM_WORDS   = 1024,
  parameter int unsigned READ_DELAY  = 2,
  parameter int unsigned WRITE_DELAY = READ_DELAY,
  parameter int unsigned STALL_MODE  = 0,
  parameter logic [7:0]  LFSR_SEED   = 8'hA5,
  parameter int unsigned READ_ONLY   = 0,
  parameter string       INIT_FILE   = ""
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [31:0]               address,
  input  logic                      read,
  input  logic                      write,
  input  logic [DATA_WIDTH-1:0]     writedata,
  input  logic [DATA_WIDTH/8-1:0]   byteenable,
  output logic                      waitrequest,
  output logic [DATA_WIDTH-1:0]     readdata,
  output logic                      bus_error
);

  localparam int unsigned BE_W     = DATA_WIDTH / 8;
  localparam int unsigned OFF_BITS = clog2(BE_W);
  localparam int unsigned IDX_W    = (MEM_WORDS > 1) ? clog2(MEM_WORDS) : 1;
  localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(MEM_WORDS) * 33'(BE_W);
  localparam logic [8:0]  RD_DLY   = 9'(READ_DELAY);
  localparam logic [8:0]  WR_DLY   = 9'(WRITE_DELAY);
  localparam bit          RO       = (READ_ONLY != 0);

  if (DATA_WIDTH < 8 || (DATA_WIDTH % 8) != 0) begin : g_bad_width
    $error("mips_avalon_ram: DATA_WIDTH must be a multiple of 8 and at least 8");
  end
  if (READ_DELAY > 255 || WRITE_DELAY > 255) begin : g_bad_delay
    $error("mips_avalon_ram: READ_DELAY/WRITE_DELAY must be 0..255");
  end
  if (STALL_MODE > 1) begin : g_bad_stall
    $error("mips_avalon_ram: STALL_MODE must be 0 or 1");
  end
  if (READ_ONLY > 1) begin : g_bad_ro
    $error("mips_avalon_ram: READ_ONLY must be 0 or 1");
  end
  if (LFSR_SEED == 8'h00) begin : g_bad_seed
    $error("mips_avalon_ram: LFSR_SEED must be non-zero");
  end
  if (MEM_WORDS == 0) begin : g_bad_depth
    $error("mips_avalon_ram: MEM_WORDS must be non-zero");
  end

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  avalon_state_t         state, state_n;
  logic [8:0]            cnt, cnt_n;
  logic [IDX_W-1:0]      lat_idx, cur_idx, rd_idx;
  logic [DATA_WIDTH-1:0] lat_wdata;
  logic [BE_W-1:0]       lat_be;
  logic                  lat_wr;
  logic                  req, hit, err_case, accept;
  logic                  lat_load, rd_load, mem_we, err_n;
  logic [1:0]            extra;

  if (STALL_MODE == 1) begin : g_stall
    logic [7:0] lfsr_q;
    logic       lfsr_unused;
    mips_lfsr8 u_lfsr (
      .clk   (clk),
      .reset (reset),
      .seed  (LFSR_SEED),
      .out   (lfsr_q)
    );
    assign extra       = lfsr_q[1:0];
    assign lfsr_unused = ^lfsr_q[7:2];
  end else begin : g_fixed
    assign extra = 2'b00;
  end

  // Zero-fill at time 0; contents survive reset
  initial begin
    for (int unsigned i = 0; i < MEM_WORDS; i++) mem[i] = '0;
  end

  assign req      = read | write;
  assign hit      = ({1'b0, address} >= {1'b0, BASE_ADDR}) && ({1'b0, address} < END_ADDR);
  assign cur_idx  = IDX_W'((address - BASE_ADDR) >> OFF_BITS);
  assign err_case = hit & ((read & write) | (write & RO));
  assign accept   = req & hit & ~err_case;

  // Reset forces waitrequest low so the master sees the stall drop with it
  assign waitrequest = req & hit & (state != ACK) & ~err_case & ~reset;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    lat_load = 1'b0;
    rd_load  = 1'b0;
    rd_idx   = lat_idx;
    mem_we   = 1'b0;
    err_n    = 1'b0;
    case (state)
      IDLE: begin
        if (err_case) begin
          err_n = 1'b1;
        end else if (accept) begin
          lat_load = 1'b1;
          cnt_n    = (write ? WR_DLY : RD_DLY) + {7'd0, extra};
          if (cnt_n == '0) begin
            // zero delay: data must already be valid in the ACK cycle
            state_n = ACK;
            rd_load = read;
            rd_idx  = cur_idx;
          end else begin
            state_n = WAIT;
          end
        end
      end
      WAIT: begin
        if (!req) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == 9'd1) begin
          state_n = ACK;
          cnt_n   = '0;
          rd_load = ~lat_wr;
        end else begin
          cnt_n = cnt - 9'd1;
        end
      end
      ACK: begin
        state_n = IDLE;
        mem_we  = req & lat_wr;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= '0;
      readdata  <= '0;
      bus_error <= 1'b0;
      lat_idx   <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
      lat_wr    <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bus_error <= err_n;
      if (lat_load) begin
        lat_idx   <= cur_idx;
        lat_wdata <= writedata;
        lat_be    <= byteenable;
        lat_wr    <= write;
      end
      if (rd_load) readdata <= mem[rd_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < BE_W; i++) begin
        if (lat_be[i]) mem[lat_idx][i*8 +: 8] <= lat_wdata[i*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_mips_avalon_ram.sv
// Self-checking bench: three slave instances share one bus and are compared
// every cycle against a transaction-level model of the memory and timing.
module tb_mips_avalon_ram;

    localparam int NI = 3;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [31:0]       address = '0;
    logic              read = 1'b0;
    logic              write = 1'b0;
    logic [31:0]       writedata = '0;
    logic [3:0]        byteenable = '0;
    logic [NI-1:0]     wr_o, be_o;
    logic [NI-1:0][31:0] rd_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mips_avalon_ram #(.DATA_WIDTH(32), .BASE_ADDR(32'hBFC00000), .MEM_WORDS(1024),
                      .READ_DELAY(2), .WRITE_DELAY(3), .STALL_MODE(0), .LFSR_SEED(8'hA5),
                      .READ_ONLY(0), .INIT_FILE("")) u_fix (
        .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable),
        .waitrequest(wr_o[0]), .readdata(rd_o[0]), .bus_error(be_o[0]));

    mips_avalon_ram #(.DATA_WIDTH(32), .BASE_ADDR(32'h00000000), .MEM_WORDS(64),
                      .READ_DELAY(1), .WRITE_DELAY(1), .STALL_MODE(1), .LFSR_SEED(8'hA5),
                      .READ_ONLY(0), .INIT_FILE("")) u_stl (
        .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable),
        .waitrequest(wr_o[1]), .readdata(rd_o[1]), .bus_error(be_o[1]));

    mips_avalon_ram #(.DATA_WIDTH(32), .BASE_ADDR(32'h10000000), .MEM_WORDS(16),
                      .READ_DELAY(0), .WRITE_DELAY(0), .STALL_MODE(0), .LFSR_SEED(8'hA5),
                      .READ_ONLY(1), .INIT_FILE("")) u_ro (
        .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
        .writedata(writedata), .byteenable(byteenable),
        .waitrequest(wr_o[2]), .readdata(rd_o[2]), .bus_error(be_o[2]));

    // ---------------- instance descriptions ----------------
    function automatic logic [31:0] base_of(input int i);
        case (i)
            0: return 32'hBFC00000;
            1: return 32'h00000000;
            default: return 32'h10000000;
        endcase
    endfunction
    function automatic int words_of(input int i);
        case (i) 0: return 1024; 1: return 64; default: return 16; endcase
    endfunction
    function automatic int rdly_of(input int i);
        case (i) 0: return 2; 1: return 1; default: return 0; endcase
    endfunction
    function automatic int wdly_of(input int i);
        case (i) 0: return 3; 1: return 1; default: return 0; endcase
    endfunction
    function automatic bit ro_of(input int i);
        return (i == 2);
    endfunction
    function automatic bit stall_of(input int i);
        return (i == 1);
    endfunction
    function automatic bit hit_of(input int i, input logic [31:0] a);
        logic [32:0] lo, hi;
        lo = {1'b0, base_of(i)};
        hi = lo + 33'(words_of(i) * 4);
        return ({1'b0, a} >= lo) && ({1'b0, a} < hi);
    endfunction
    function automatic int idx_of(input int i, input logic [31:0] a);
        return int'((a - base_of(i)) >> 2);
    endfunction
    function automatic int inst_of(input logic [31:0] a);
        for (int i = 0; i < NI; i++) if (hit_of(i, a)) return i;
        return -1;
    endfunction
    function automatic logic [7:0] lfsr_next(input logic [7:0] x);
        return x[0] ? ((x >> 1) ^ 8'hB8) : (x >> 1);
    endfunction

    // ---------------- reference model state ----------------
    logic [31:0] mmem [NI][1024];
    int          m_el  [NI];   // cycles elapsed in the current transfer
    int          m_lat [NI];   // wait cycles for the current transfer
    logic [31:0] m_rd  [NI];   // last completed read data
    bit          m_err [NI];   // bus_error due this cycle
    logic [7:0]  m_lfsr = 8'hA5;

    task automatic check(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d] at %0t: actual=%h required=%h", nm, inst, $time, act, exp);
        end
    endtask

    // Model update: one step per rising edge from the inputs held in that cycle
    always @(posedge clk) begin
        for (int i = 0; i < NI; i++) begin
            bit req, h, er;
            int k;
            req = read | write;
            h   = hit_of(i, address);
            er  = h && ((read && write) || (write && ro_of(i)));
            if (reset) begin
                m_el[i]  = 0;
                m_rd[i]  = '0;
                m_err[i] = 1'b0;
            end else begin
                m_err[i] = er;
                if (req && h && !er) begin
                    if (m_el[i] == 0)
                        m_lat[i] = (write ? wdly_of(i) : rdly_of(i)) + (stall_of(i) ? int'(m_lfsr[1:0]) : 0);
                    if (m_el[i] == m_lat[i] + 1) begin
                        k = idx_of(i, address);
                        if (write) begin
                            for (int b = 0; b < 4; b++)
                                if (byteenable[b]) mmem[i][k][b*8 +: 8] = writedata[b*8 +: 8];
                        end else begin
                            m_rd[i] = mmem[i][k];
                        end
                        m_el[i] = 0;
                    end else begin
                        m_el[i]++;
                    end
                end else begin
                    m_el[i] = 0;
                end
            end
        end
        m_lfsr = reset ? 8'hA5 : lfsr_next(m_lfsr);
    end

    // Compare every instance's outputs each cycle, away from the rising edge
    always @(negedge clk) begin
        for (int i = 0; i < NI; i++) begin
            bit          req, h, er, ew, eb;
            logic [31:0] erd;
            req = read | write;
            h   = hit_of(i, address);
            er  = h && ((read && write) || (write && ro_of(i)));
            if (reset) begin
                ew = 1'b0; eb = 1'b0; erd = '0;
            end else begin
                ew  = req && h && !er && (m_el[i] == 0 || m_el[i] < m_lat[i] + 1);
                eb  = m_err[i];
                erd = m_rd[i];
                if (req && h && !er && read && m_el[i] > 0 && m_el[i] == m_lat[i] + 1)
                    erd = mmem[i][idx_of(i, address)];
            end
            check("waitrequest", i, 32'(wr_o[i]), 32'(ew));
            check("bus_error",   i, 32'(be_o[i]), 32'(eb));
            check("readdata",    i, rd_o[i], erd);
        end
    end

    // ---------------- stimulus ----------------
    // Called just after a rising edge; returns just after the completing edge
    task automatic xfer(input logic [31:0] a, input bit rd, input bit wr, input logic [31:0] d,
                        input logic [3:0] be, output int edges, output logic [31:0] rdata);
        bit w;
        int k;
        address = a; read = rd; write = wr; writedata = d; byteenable = be;
        edges = 0;
        rdata = '0;
        k = inst_of(a);
        forever begin
            @(negedge clk);
            w = |wr_o;
            if (k >= 0) rdata = rd_o[k];
            @(posedge clk);
            edges++;
            if (!w) break;
            if (edges >= 400) begin
                n_fail++;
                $display("FAIL xfer_timeout: address=%h still stalled after %0d edges", a, edges);
                break;
            end
        end
        #1;
        read = 1'b0; write = 1'b0;
    endtask

    task automatic do_reset();
        read = 1'b0; write = 1'b0; reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    localparam int N_WR = 30;
    localparam int N_RD = 100;
    logic [31:0] op_addr [N_WR + N_RD];
    logic [31:0] op_data [N_WR + N_RD];
    logic [3:0]  op_be   [N_WR + N_RD];
    int          op_gap  [N_WR + N_RD];
    int          lat_a   [2][N_RD];

    task automatic run_stall(input int run);
        int e, r;
        logic [31:0] rv;
        do_reset();
        r = 0;
        for (int j = 0; j < N_WR + N_RD; j++) begin
            if (j < N_WR) begin
                xfer(op_addr[j], 1'b0, 1'b1, op_data[j], op_be[j], e, rv);
            end else begin
                xfer(op_addr[j], 1'b1, 1'b0, '0, 4'h0, e, rv);
                lat_a[run][r] = e;
                r++;
            end
            check("stall_latency_in_3_to_6", 1, 32'(e >= 3 && e <= 6), 32'd1);
            repeat (op_gap[j]) @(posedge clk);
            if (op_gap[j] > 0) #1;
        end
    endtask

    initial begin : main
        int e;
        logic [31:0] rv;
        for (int i = 0; i < NI; i++) begin
            for (int k = 0; k < 1024; k++) mmem[i][k] = '0;
            m_el[i] = 0; m_lat[i] = 0; m_rd[i] = '0; m_err[i] = 1'b0;
        end
        for (int j = 0; j < N_WR + N_RD; j++) begin
            op_addr[j] = ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
            op_data[j] = $urandom;
            op_be[j]   = 4'($urandom_range(0, 15));
            op_gap[j]  = $urandom_range(0, 2);
        end

        do_reset();

        // Fixed-delay write then read: WRITE_DELAY=3 -> 5 edges, READ_DELAY=2 -> 4 edges
        xfer(32'hBFC00000, 1'b0, 1'b1, 32'h3C011234, 4'hF, e, rv);
        check("fix_write_edges", 0, e, 5);
        xfer(32'hBFC00000, 1'b1, 1'b0, '0, 4'h0, e, rv);
        check("fix_read_edges", 0, e, 4);
        check("fix_read_data", 0, rv, 32'h3C011234);

        // Byte-lane write on the base-0 stalling instance
        xfer(32'h00000004, 1'b0, 1'b1, 32'h11223344, 4'hF, e, rv);
        xfer(32'h00000004, 1'b0, 1'b1, 32'hAABBCCDD, 4'b0101, e, rv);
        check("be_write_edges_in_3_to_6", 1, 32'(e >= 3 && e <= 6), 32'd1);
        xfer(32'h00000006, 1'b1, 1'b0, '0, 4'h0, e, rv);
        check("be_read_data", 1, rv, 32'h11BB33DD);

        // Read-only write: zero wait, one-cycle error pulse, memory untouched
        xfer(32'h10000000, 1'b0, 1'b1, 32'hFFFFFFFF, 4'hF, e, rv);
        check("ro_err_edges", 2, e, 1);
        @(negedge clk);
        check("ro_err_pulse_high", 2, 32'(be_o[2]), 32'd1);
        @(negedge clk);
        check("ro_err_pulse_low", 2, 32'(be_o[2]), 32'd0);
        @(posedge clk); #1;
        xfer(32'h10000000, 1'b1, 1'b0, '0, 4'h0, e, rv);
        check("ro_read_edges", 2, e, 2);
        check("ro_read_data", 2, rv, 32'h0);

        // read and write together
        xfer(32'hBFC00000, 1'b1, 1'b1, 32'hFFFFFFFF, 4'hF, e, rv);
        check("rw_err_edges", 0, e, 1);
        @(negedge clk);
        check("rw_err_pulse", 0, 32'(be_o[0]), 32'd1);
        @(posedge clk); #1;
        xfer(32'hBFC00000, 1'b1, 1'b0, '0, 4'h0, e, rv);
        check("rw_err_mem_kept", 0, rv, 32'h3C011234);

        // Abort a write after one WAIT cycle; next read must start from IDLE
        address = 32'hBFC00010; writedata = 32'h00000055; byteenable = 4'hF; write = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        write = 1'b0;
        @(posedge clk); #1;
        xfer(32'hBFC00010, 1'b1, 1'b0, '0, 4'h0, e, rv);
        check("abort_next_read_edges", 0, e, 4);
        check("abort_mem_kept", 0, rv, 32'h0);

        // Miss just past the end of the fixed window
        xfer(32'hBFC01000, 1'b1, 1'b0, '0, 4'h0, e, rv);
        check("miss_edges", 0, e, 1);
        check("miss_readdata_held", 0, rd_o[0], 32'h0);

        // Reset during WAIT of a write
        address = 32'hBFC00000; writedata = 32'hFFFFFFFF; byteenable = 4'hF; write = 1'b1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("reset_wait_wr_low", 0, 32'(wr_o[0]), 32'd0);
        check("reset_readdata_zero", 0, rd_o[0], 32'h0);
        @(posedge clk); #1;
        reset = 1'b0; write = 1'b0;
        xfer(32'hBFC00000, 1'b1, 1'b0, '0, 4'h0, e, rv);
        check("reset_mem_kept", 0, rv, 32'h3C011234);
        check("reset_read_edges", 0, e, 4);

        // Random stalling traffic, replayed after reset for determinism
        run_stall(0);
        run_stall(1);
        for (int r = 0; r < N_RD; r++) check("stall_rerun_latency", 1, lat_a[1][r], lat_a[0][r]);

        @(posedge clk); #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

endmodule
